// File: rtl/mnist_window_streamer_if.sv
// rtl/mnist_window_streamer_if.sv - pixel stream in, 5x5 window out, between streamer and CNN
interface mnist_window_streamer_if #(
  parameter int PW = 8,
  parameter int K  = 5
);
  logic              PIX_VALID;
  logic [PW-1:0]     PIX_IN;
  logic              PIX_READY;
  logic              WIN_ACK;
  logic              START;
  logic [4:0]        X;
  logic [4:0]        Y;
  logic [K*K*PW-1:0] IMGIN;
  logic              IMG_DONE;

  modport master (
    input  PIX_VALID, PIX_IN, WIN_ACK,
    output PIX_READY, START, X, Y, IMGIN, IMG_DONE
  );

  modport slave (
    output PIX_VALID, PIX_IN, WIN_ACK,
    input  PIX_READY, START, X, Y, IMGIN, IMG_DONE
  );
endinterface

// File: rtl/mnist_window_streamer.sv
// rtl/mnist_window_streamer.sv - stores one MNIST image and walks every KxK window for the CNN
module mnist_window_streamer #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int PW    = 8
) (
  input logic                 CLK,
  input logic                 nRST,
  mnist_window_streamer_if.master win
);
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int NPOS  = IMG_W - K + 1;
  localparam int NSLOT = K * K;
  localparam int AW    = $clog2(NPIX);
  localparam int CW    = $clog2(NPOS);
  localparam int SW    = $clog2(NSLOT);
  localparam int IW    = $clog2(K);

  typedef enum logic [1:0] {S_LOAD, S_GATHER, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mem [NPIX];
  logic [PW-1:0]   win_q [NSLOT];
  logic [AW-1:0]   load_cnt;
  logic [SW-1:0]   slot;
  logic [IW-1:0]   gi, gj;
  logic [CW-1:0]   xc, yc, x_q, y_q;
  logic            done_q;
  logic            accept, last_pix, last_slot, last_col, last_row;
  logic            start_c, ready_c;
  logic [AW-1:0]   rd_addr;
  logic [NSLOT*PW-1:0] imgin_flat;

  assign accept    = win.PIX_VALID && (state_q == S_LOAD) && nRST;
  assign last_pix  = (load_cnt == AW'(NPIX - 1));
  assign last_slot = (slot == SW'(NSLOT - 1));
  assign last_col  = (yc == CW'(NPOS - 1));
  assign last_row  = (xc == CW'(NPOS - 1));
  assign rd_addr   = AW'((AW'(xc) + AW'(gi)) * AW'(IMG_W)) + AW'(yc) + AW'(gj);

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    ready_c = !nRST;
    case (state_q)
      S_LOAD: begin
        ready_c = 1'b1;
        if (accept && last_pix) state_d = S_GATHER;
      end
      S_GATHER: if (last_slot) state_d = S_ISSUE;
      S_ISSUE: begin
        start_c = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (win.WIN_ACK) state_d = (last_row && last_col) ? S_LOAD : S_GATHER;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Image memory has no reset; its contents only matter after a full reload.
  always_ff @(posedge CLK) begin
    if (accept) mem[load_cnt] <= win.PIX_IN;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      load_cnt <= '0;
      slot     <= '0;
      gi       <= '0;
      gj       <= '0;
      xc       <= '0;
      yc       <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      for (int s = 0; s < NSLOT; s++) win_q[s] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (accept) load_cnt <= last_pix ? '0 : load_cnt + 1'b1;
        end
        S_GATHER: begin
          win_q[slot] <= mem[rd_addr];
          if (last_slot) begin
            // Publish the origin as the last slot lands so X/Y are valid alongside START.
            slot <= '0;
            gi   <= '0;
            gj   <= '0;
            x_q  <= xc;
            y_q  <= yc;
          end else begin
            slot <= slot + 1'b1;
            if (gj == IW'(K - 1)) begin
              gj <= '0;
              gi <= gi + 1'b1;
            end else begin
              gj <= gj + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (win.WIN_ACK) begin
            if (!last_col) begin
              yc <= yc + 1'b1;
            end else if (!last_row) begin
              yc <= '0;
              xc <= xc + 1'b1;
            end else begin
              yc     <= '0;
              xc     <= '0;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imgin_flat = '0;
    for (int s = 0; s < NSLOT; s++) imgin_flat[s*PW +: PW] = win_q[s];
  end

  assign win.PIX_READY = ready_c;
  assign win.START     = start_c;
  assign win.X         = x_q;
  assign win.Y         = y_q;
  assign win.IMGIN     = imgin_flat;
  assign win.IMG_DONE  = done_q;
endmodule
